// File: rtl/holy_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : holy_core_pkg
//  Description : Shared types and constants for the holy core AXI-Lite
//                slaves: the lite slave state encoding, the AXI response
//                codes and a byte-strobe merge helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package holy_core_pkg;

    // Lite slave transaction phases.
    typedef enum logic [1:0] {
        SLAVE_IDLE                = 2'd0,
        LITE_RECEIVING_WRITE_DATA = 2'd1,
        LITE_SENDING_WRITE_RES    = 2'd2,
        LITE_SENDING_READ_DATA    = 2'd3
    } axi_state_slave_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Replace only the bytes of old_val whose strobe bit is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_val[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/holy_axil_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : holy_axil_addr_decode
//  Description : Combinational AXI-Lite address decoder for the register
//                bank. Turns a byte address into a word index, a hit flag
//                (aligned, in range, upper bits clear) and a read-only flag.
//  Ports       : addr_i  - byte address
//                idx_o   - register index, addr_i[IDX_W+1:2]
//                hit_o   - address maps onto an existing register
//                ro_o    - hit on a register marked read-only
//  Revision    : 1.0 - initial release
// ============================================================================
module holy_axil_addr_decode #(
    parameter int                  NUM_REGS   = 8,
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  IDX_W      = 3,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  hit_o,
    output logic                  ro_o
);

    // One extra bit so NUM_REGS itself is representable (e.g. 64 in 7 bits).
    localparam logic [IDX_W:0] C_NUM_REGS = (IDX_W + 1)'(NUM_REGS);

    logic upper_zero;

    generate
        if (ADDR_WIDTH > IDX_W + 2) begin : g_upper
            assign upper_zero = (addr_i[ADDR_WIDTH-1:IDX_W+2] == '0);
        end else begin : g_no_upper
            assign upper_zero = 1'b1;
        end
    endgenerate

    assign idx_o = addr_i[IDX_W+1:2];
    // The range compare matters only when NUM_REGS is not a power of two.
    assign hit_o = (addr_i[1:0] == 2'b00) && upper_zero &&
                   ({1'b0, idx_o} < C_NUM_REGS);
    assign ro_o  = hit_o && RO_MASK[idx_o];

endmodule
`default_nettype wire

// File: rtl/holy_axil_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : holy_axil_regbank
//  Description : Parametrised AXI-Lite slave register bank. NUM_REGS 32-bit
//                registers with byte strobes, per-register read-only masking
//                (RO values come from hw_status_i), a one-cycle write-commit
//                pulse per register and SLVERR for bad addresses or writes
//                to RO registers. One outstanding transaction at a time.
//  Ports       : clk, rst             - clock, asynchronous active-high reset
//                s_axi_aw*/w*/b*      - AXI-Lite write channels
//                s_axi_ar*/r*         - AXI-Lite read channels
//                regs_o               - RW register contents, reg i at [32*i+:32]
//                hw_status_i          - status words returned for RO registers
//                wr_pulse_o           - pulse on committed write to reg i
//  Revision    : 1.0 - initial release
// ============================================================================
module holy_axil_regbank
    import holy_core_pkg::*;
#(
    parameter int                  NUM_REGS   = 8,
    parameter int                  ADDR_WIDTH = 32,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
    parameter logic [31:0]         RST_VALUE  = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,

    input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,

    output logic [NUM_REGS*32-1:0]   regs_o,
    input  logic [NUM_REGS*32-1:0]   hw_status_i,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

    // A single-register bank still needs a 1-bit index to keep slices legal.
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    axi_state_slave_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    rvalid_q, rvalid_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;

    logic [IDX_W-1:0]        wr_idx, rd_idx;
    logic                    wr_hit, wr_ro, rd_hit, rd_ro;
    logic                    w_handshake;
    logic                    wr_commit;

    logic [31:0]             reg_arr    [NUM_REGS];
    logic [31:0]             status_arr [NUM_REGS];

    // Write path decodes the latched AW address; read path decodes the live
    // AR address because read data is captured on the AR handshake itself.
    holy_axil_addr_decode #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_W      (IDX_W),
        .RO_MASK    (RO_MASK)
    ) u_wr_decode (
        .addr_i (awaddr_q),
        .idx_o  (wr_idx),
        .hit_o  (wr_hit),
        .ro_o   (wr_ro)
    );

    holy_axil_addr_decode #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_W      (IDX_W),
        .RO_MASK    (RO_MASK)
    ) u_rd_decode (
        .addr_i (s_axi_araddr),
        .idx_o  (rd_idx),
        .hit_o  (rd_hit),
        .ro_o   (rd_ro)
    );

    assign w_handshake = (state_q == LITE_RECEIVING_WRITE_DATA) && s_axi_wvalid;
    // Only a legal RW target with at least one strobe changes state.
    assign wr_commit   = w_handshake && wr_hit && !wr_ro && (s_axi_wstrb != 4'h0);

    // ------------------------------------------------------------------
    // Register storage: RW registers get flops, RO registers get none.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            assign status_arr[i] = hw_status_i[32*i +: 32];

            if (RO_MASK[i]) begin : g_ro
                assign reg_arr[i] = '0;
            end else begin : g_rw
                logic [31:0] reg_q, reg_d;

                always_comb begin
                    reg_d = reg_q;
                    if (wr_commit && (wr_idx == IDX_W'(i))) begin
                        reg_d = apply_wstrb(reg_q, s_axi_wdata, s_axi_wstrb);
                    end
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        reg_q <= RST_VALUE;
                    end else begin
                        reg_q <= reg_d;
                    end
                end

                assign reg_arr[i] = reg_q;
            end

            assign regs_o[32*i +: 32] = reg_arr[i];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        awaddr_d   = awaddr_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        wr_pulse_d = '0;

        case (state_q)
            SLAVE_IDLE: begin
                if (s_axi_awvalid) begin
                    awaddr_d = s_axi_awaddr;
                    state_d  = LITE_RECEIVING_WRITE_DATA;
                end else if (s_axi_arvalid) begin
                    rvalid_d = 1'b1;
                    state_d  = LITE_SENDING_READ_DATA;
                    if (!rd_hit) begin
                        rresp_d = AXI_RESP_SLVERR;
                        rdata_d = '0;
                    end else begin
                        rresp_d = AXI_RESP_OKAY;
                        rdata_d = rd_ro ? status_arr[rd_idx] : reg_arr[rd_idx];
                    end
                end
            end

            LITE_RECEIVING_WRITE_DATA: begin
                if (s_axi_wvalid) begin
                    bvalid_d = 1'b1;
                    bresp_d  = (wr_hit && !wr_ro) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                    state_d  = LITE_SENDING_WRITE_RES;
                    if (wr_commit) begin
                        wr_pulse_d[wr_idx] = 1'b1;
                    end
                end
            end

            LITE_SENDING_WRITE_RES: begin
                if (s_axi_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = SLAVE_IDLE;
                end
            end

            LITE_SENDING_READ_DATA: begin
                if (s_axi_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = SLAVE_IDLE;
                end
            end

            default: begin
                state_d = SLAVE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SLAVE_IDLE;
            awaddr_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= AXI_RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= AXI_RESP_OKAY;
            rdata_q    <= '0;
            wr_pulse_q <= '0;
        end else begin
            state_q    <= state_d;
            awaddr_q   <= awaddr_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Readies are gated by rst so they drop the moment reset asserts, even
    // though the state register already sits in SLAVE_IDLE.
    assign s_axi_awready = (state_q == SLAVE_IDLE) && !rst;
    assign s_axi_arready = (state_q == SLAVE_IDLE) && !s_axi_awvalid && !rst;
    assign s_axi_wready  = (state_q == LITE_RECEIVING_WRITE_DATA);
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign wr_pulse_o    = wr_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_holy_axil_regbank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_holy_axil_regbank
//  Description : Self-checking bench for holy_axil_regbank. Expected write
//                and read responses are queued when a transaction is driven
//                and compared by a monitor when the DUT completes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_holy_axil_regbank;
    import holy_core_pkg::*;

    localparam int          NUM_REGS   = 8;
    localparam int          ADDR_WIDTH = 32;
    localparam logic [7:0]  RO_MASK    = 8'h80;
    localparam logic [31:0] RST_VALUE  = 32'hA5A5_0000;
    localparam int          LIMIT      = 20;

    logic                    clk, rst;
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr, s_axi_araddr;
    logic                    s_axi_awvalid, s_axi_awready;
    logic [31:0]             s_axi_wdata, s_axi_rdata;
    logic [3:0]              s_axi_wstrb;
    logic                    s_axi_wvalid, s_axi_wready;
    logic [1:0]              s_axi_bresp, s_axi_rresp;
    logic                    s_axi_bvalid, s_axi_bready;
    logic                    s_axi_arvalid, s_axi_arready;
    logic                    s_axi_rvalid, s_axi_rready;
    logic [NUM_REGS*32-1:0]  regs_o, hw_status_i;
    logic [NUM_REGS-1:0]     wr_pulse_o;

    holy_axil_regbank #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RO_MASK    (RO_MASK),
        .RST_VALUE  (RST_VALUE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .regs_o        (regs_o),
        .hw_status_i   (hw_status_i),
        .wr_pulse_o    (wr_pulse_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t        wq[$];
    exp_t        rq[$];
    exp_t        mon_e;
    logic [31:0] model [NUM_REGS];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < NUM_REGS; i++) begin
            f[32*i +: 32] = RO_MASK[i] ? 32'h0 : model[i];
        end
        return f;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_REGS; i++) model[i] = RST_VALUE;
    endfunction

    // Handshakes are visible at the negedge before the posedge they complete on.
    always @(negedge clk) begin
        if (!rst && s_axi_bvalid && s_axi_bready) begin
            if (wq.size() == 0) check("b_unexpected", 256'(1), 256'(0));
            else begin
                mon_e = wq.pop_front();
                check("bresp", 256'(s_axi_bresp), 256'(mon_e.resp));
            end
        end
        if (!rst && s_axi_rvalid && s_axi_rready) begin
            if (rq.size() == 0) check("r_unexpected", 256'(1), 256'(0));
            else begin
                mon_e = rq.pop_front();
                check("rresp", 256'(s_axi_rresp), 256'(mon_e.resp));
                check("rdata", 256'(s_axi_rdata), 256'(mon_e.data));
            end
        end
    end

    task automatic drive_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(posedge clk); #1;
        s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_awready && n < LIMIT) begin @(negedge clk); n++; end
        check("awready_wait", 256'(s_axi_awready), 256'(1));
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_wready && n < LIMIT) begin @(negedge clk); n++; end
        check("wready_wait", 256'(s_axi_wready), 256'(1));
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int stall);
        exp_t        e;
        logic [7:0]  pulse;
        logic [1:0]  resp0;
        logic        hit, ro;
        int          idx;
        idx   = int'(addr[4:2]);
        hit   = (addr[1:0] == 2'b00) && (addr[31:5] == '0);
        ro    = hit && RO_MASK[idx];
        pulse = '0;
        e.data = '0;
        if (hit && !ro) begin
            e.resp = AXI_RESP_OKAY;
            if (strb != 4'h0) begin
                for (int k = 0; k < 4; k++)
                    if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
                pulse[idx] = 1'b1;
            end
        end else begin
            e.resp = AXI_RESP_SLVERR;
        end
        wq.push_back(e);
        drive_aw_w(addr, data, strb);
        @(negedge clk);
        check("bvalid_latency", 256'(s_axi_bvalid), 256'(1));
        check("wr_pulse", 256'(wr_pulse_o), 256'(pulse));
        resp0 = s_axi_bresp;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); @(negedge clk);
            check("bvalid_hold", 256'(s_axi_bvalid), 256'(1));
            check("bresp_hold", 256'(s_axi_bresp), 256'(resp0));
            check("awready_stall", 256'(s_axi_awready), 256'(0));
        end
        @(posedge clk); #1; s_axi_bready = 1'b1;
        @(negedge clk);
        check("wr_pulse_off", 256'(wr_pulse_o), 256'(0));
        @(posedge clk); #1; s_axi_bready = 1'b0;
        @(negedge clk);
        check("bvalid_drop", 256'(s_axi_bvalid), 256'(0));
        check("regs_after_write", 256'(regs_o), model_flat());
    endtask

    task automatic do_read(input logic [31:0] addr, input int stall);
        exp_t        e;
        logic [31:0] d0;
        logic        hit;
        int          idx, n;
        idx = int'(addr[4:2]);
        hit = (addr[1:0] == 2'b00) && (addr[31:5] == '0);
        if (!hit) begin
            e.resp = AXI_RESP_SLVERR; e.data = '0;
        end else begin
            e.resp = AXI_RESP_OKAY;
            e.data = RO_MASK[idx] ? hw_status_i[32*idx +: 32] : model[idx];
        end
        rq.push_back(e);
        @(posedge clk); #1;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_arready && n < LIMIT) begin @(negedge clk); n++; end
        check("arready_wait", 256'(s_axi_arready), 256'(1));
        @(posedge clk); #1; s_axi_arvalid = 1'b0;
        @(negedge clk);
        check("rvalid_latency", 256'(s_axi_rvalid), 256'(1));
        d0 = s_axi_rdata;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); @(negedge clk);
            check("rvalid_hold", 256'(s_axi_rvalid), 256'(1));
            check("rdata_hold", 256'(s_axi_rdata), 256'(d0));
            check("arready_stall", 256'(s_axi_arready), 256'(0));
            check("awready_rstall", 256'(s_axi_awready), 256'(0));
        end
        @(posedge clk); #1; s_axi_rready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1; s_axi_rready = 1'b0;
        @(negedge clk);
        check("rvalid_drop", 256'(s_axi_rvalid), 256'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) hw_status_i[32*i +: 32] = 32'hC0DE_0000 | 32'(i);
        hw_status_i[32*7 +: 32] = 32'h0000_1234;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 256'(s_axi_awready), 256'(0));
        check("rst_arready", 256'(s_axi_arready), 256'(0));
        check("rst_wready",  256'(s_axi_wready),  256'(0));
        check("rst_bvalid",  256'(s_axi_bvalid),  256'(0));
        check("rst_rvalid",  256'(s_axi_rvalid),  256'(0));
        check("rst_bresp",   256'(s_axi_bresp),   256'(0));
        check("rst_rresp",   256'(s_axi_rresp),   256'(0));
        check("rst_rdata",   256'(s_axi_rdata),   256'(0));
        check("rst_pulse",   256'(wr_pulse_o),    256'(0));
        check("rst_regs",    256'(regs_o),        model_flat());
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("idle_awready", 256'(s_axi_awready), 256'(1));
        check("idle_arready", 256'(s_axi_arready), 256'(1));

        // Reset in the middle of a write response
        do_write(32'h8, 32'h1122_3344, 4'hF, 0);
        drive_aw_w(32'hC, 32'h5566_7788, 4'hF);
        @(negedge clk);
        check("pre_rst_bvalid", 256'(s_axi_bvalid), 256'(1));
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("mid_rst_bvalid",  256'(s_axi_bvalid),  256'(0));
        check("mid_rst_awready", 256'(s_axi_awready), 256'(0));
        check("mid_rst_regs",    256'(regs_o),        model_flat());
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_awready", 256'(s_axi_awready), 256'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_reissue_bvalid", 256'(s_axi_bvalid), 256'(0));
        end

        // Full and partial writes to reg1, read back
        do_write(32'h4, 32'hDEAD_BEEF, 4'hF, 0);
        do_write(32'h4, 32'h0000_00AA, 4'h1, 0);
        do_read(32'h4, 0);
        // RO register
        do_write(32'h1C, 32'hFFFF_FFFF, 4'hF, 0);
        do_read(32'h1C, 0);
        // Decode errors
        do_read(32'h22, 0);
        do_read(32'h40, 0);
        do_read(32'h1000_0004, 0);
        do_write(32'h40, 32'h0BAD_0BAD, 4'hF, 0);
        do_write(32'h6, 32'h0BAD_0BAD, 4'hF, 0);
        // Zero strobe: OKAY, nothing changes
        do_write(32'h10, 32'h7777_7777, 4'h0, 0);
        // Stalled responses
        do_write(32'h14, 32'hCAFE_F00D, 4'hA, 5);
        do_read(32'h14, 5);
        do_read(32'h1C, 5);

        // Simultaneous AW and AR to reg0: write first, then read sees it
        model[0] = 32'h5;
        e.resp = AXI_RESP_OKAY; e.data = '0;
        wq.push_back(e);
        e.data = 32'h5;
        rq.push_back(e);
        @(posedge clk); #1;
        s_axi_awaddr = 32'h0; s_axi_awvalid = 1'b1;
        s_axi_araddr = 32'h0; s_axi_arvalid = 1'b1;
        @(negedge clk);
        check("race_awready", 256'(s_axi_awready), 256'(1));
        check("race_arready", 256'(s_axi_arready), 256'(0));
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wdata = 32'h5; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(negedge clk);
        check("race_wready", 256'(s_axi_wready), 256'(1));
        check("race_ar_wait", 256'(s_axi_arready), 256'(0));
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
        @(negedge clk);
        check("race_pulse", 256'(wr_pulse_o), 256'(8'h01));
        check("race_rvalid_wait", 256'(s_axi_rvalid), 256'(0));
        @(posedge clk); #1; s_axi_bready = 1'b0;
        @(negedge clk);
        check("race_ar_now", 256'(s_axi_arready), 256'(1));
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        @(negedge clk);
        check("race_rvalid", 256'(s_axi_rvalid), 256'(1));
        @(posedge clk); #1; s_axi_rready = 1'b0;

        // Short random mix
        for (int t = 0; t < 24; t++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 9)) << 2;
            if ($urandom_range(0, 7) == 0) a = a | 32'h2;
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("wq_drained", 256'(wq.size()), 256'(0));
        check("rq_drained", 256'(rq.size()), 256'(0));
        check("final_regs", 256'(regs_o), model_flat());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
